// File: rtl/mmp_iddmm_loader_pkg.sv
// Shared sizing and state encoding for the IDDMM loader front-end.
//   K      : operand word width
//   N      : words per operand
//   ADDR_W : core operand word address width
//   CNT_W  : width of counters that must also hold the value N
package mmp_iddmm_loader_pkg;

  localparam int K      = 128;
  localparam int N      = 32;
  localparam int ADDR_W = $clog2(N);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_X,
    ST_LD_Y,
    ST_LD_M,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // The input stream is only consumed while a job is being loaded.
  function automatic logic is_load_state(state_e s);
    return (s == ST_IDLE) || (s == ST_LD_X) || (s == ST_LD_Y) || (s == ST_LD_M);
  endfunction

endpackage

// File: rtl/mmp_iddmm_loader_if.sv
// Bus bundle between the loader and its surroundings.
//   s_*      : job word input stream (m1, X, Y, M)
//   wr_*     : core operand RAM write port
//   task_*   : core request / result handshake
//   m_*      : result word output stream
//   busy/err : status
// Modport slave is the loader view, master is the environment view.
interface mmp_iddmm_loader_if;
  import mmp_iddmm_loader_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [K-1:0]      s_data;

  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_x;
  logic [K-1:0]      wr_y;
  logic [K-1:0]      wr_m;
  logic [K-1:0]      wr_m1;

  logic              task_req;
  logic              task_end;
  logic              task_grant;
  logic [K-1:0]      task_res;

  logic              m_valid;
  logic              m_ready;
  logic [K-1:0]      m_data;
  logic              m_last;

  logic              busy;
  logic              err;

  modport slave (
    input  s_valid, s_data, task_end, task_grant, task_res, m_ready,
    output s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1,
           task_req, m_valid, m_data, m_last, busy, err
  );

  modport master (
    output s_valid, s_data, task_end, task_grant, task_res, m_ready,
    input  s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1,
           task_req, m_valid, m_data, m_last, busy, err
  );

endinterface

// File: rtl/mmp_iddmm_loader_ram.sv
// Simple DEPTH x WIDTH RAM: synchronous write, asynchronous read
// (maps to distributed RAM). Contents are not reset.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module mmp_iddmm_loader_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmp_iddmm_loader.sv
// Front-end for mmp_iddmm_sp. Loads one job (m1, X, Y, M) from a word
// stream, writes the core operand RAM while M streams in, requests the
// core, collects its result words and replays them as a backpressured
// output stream.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : mmp_iddmm_loader_if.slave (stream in, core write, core task,
//           stream out, busy/err)
//
// state | meaning
// IDLE  | waiting for the m1 word of a new job
// LD_X  | buffering X words
// LD_Y  | buffering Y words
// LD_M  | each M word triggers one core operand write
// RUN   | task_req held, result words captured into rbuf
// DRAIN | captured result words presented on the output stream
module mmp_iddmm_loader
  import mmp_iddmm_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mmp_iddmm_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;

  logic              wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_x_q, wr_x_d;
  logic [K-1:0]      wr_y_q, wr_y_d;
  logic [K-1:0]      wr_m_q, wr_m_d;
  logic [K-1:0]      wr_m1_q, wr_m1_d;
  logic              task_req_q, task_req_d;
  logic              m_valid_q, m_valid_d;
  logic [K-1:0]      m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              err_q, err_d;

  logic              s_ready;
  logic              s_beat;
  logic              m_accept;
  logic              grant_take;
  logic              grant_drop;
  logic [CNT_W-1:0]  rcnt_inc;
  logic [K-1:0]      x_rd, y_rd, r_rd;

  assign s_ready    = is_load_state(state_q);
  assign s_beat     = bus.s_valid && s_ready;
  assign m_accept   = m_valid_q && bus.m_ready;
  assign grant_take = (state_q == ST_RUN) && bus.task_grant && (rcnt_q < CNT_FULL);
  assign grant_drop = (state_q == ST_RUN) && bus.task_grant && (rcnt_q == CNT_FULL);
  // Count including a grant in this same cycle, so a task_end that
  // coincides with the final grant sees the complete total.
  assign rcnt_inc   = rcnt_q + CNT_W'(grant_take);

  mmp_iddmm_loader_ram #(.DEPTH(N), .WIDTH(K)) u_xbuf (
    .clk     (clk),
    .we_i    (s_beat && (state_q == ST_LD_X)),
    .waddr_i (idx_q),
    .wdata_i (bus.s_data),
    .raddr_i (idx_q),
    .rdata_o (x_rd)
  );

  mmp_iddmm_loader_ram #(.DEPTH(N), .WIDTH(K)) u_ybuf (
    .clk     (clk),
    .we_i    (s_beat && (state_q == ST_LD_Y)),
    .waddr_i (idx_q),
    .wdata_i (bus.s_data),
    .raddr_i (idx_q),
    .rdata_o (y_rd)
  );

  mmp_iddmm_loader_ram #(.DEPTH(N), .WIDTH(K)) u_rbuf (
    .clk     (clk),
    .we_i    (grant_take),
    .waddr_i (rcnt_q[ADDR_W-1:0]),
    .wdata_i (bus.task_res),
    .raddr_i (ptr_q[ADDR_W-1:0]),
    .rdata_o (r_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rcnt_q     <= '0;
      ptr_q      <= '0;
      wr_ena_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_m_q     <= '0;
      wr_m1_q    <= '0;
      task_req_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rcnt_q     <= rcnt_d;
      ptr_q      <= ptr_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_m_q     <= wr_m_d;
      wr_m1_q    <= wr_m1_d;
      task_req_q <= task_req_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rcnt_d     = rcnt_q;
    ptr_d      = ptr_q;
    wr_ena_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_m_d     = wr_m_q;
    wr_m1_d    = wr_m1_q;
    task_req_d = task_req_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (s_beat) begin
          wr_m1_d = bus.s_data;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_LD_X;
        end
      end

      ST_LD_X, ST_LD_Y: begin
        if (s_beat) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (state_q == ST_LD_X) ? ST_LD_Y : ST_LD_M;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_LD_M: begin
        if (s_beat) begin
          wr_ena_d  = 1'b1;
          wr_addr_d = idx_q;
          wr_x_d    = x_rd;
          wr_y_d    = y_rd;
          wr_m_d    = bus.s_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            rcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        // Registered, so the request rises one cycle after the last write.
        task_req_d = 1'b1;
        rcnt_d     = rcnt_inc;
        if (grant_drop) err_d = 1'b1;
        if (bus.task_end) begin
          task_req_d = 1'b0;
          ptr_d      = '0;
          if (rcnt_inc != CNT_FULL) err_d = 1'b1;
          state_d = (rcnt_inc == '0) ? ST_IDLE : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Output register refills whenever empty or being emptied.
        if (!m_valid_q || m_accept) begin
          if (ptr_q < rcnt_q) begin
            m_valid_d = 1'b1;
            m_data_d  = r_rd;
            m_last_d  = (ptr_q == rcnt_q - 1'b1);
            ptr_d     = ptr_q + 1'b1;
          end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.s_ready  = s_ready;
  assign bus.wr_ena   = wr_ena_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_x     = wr_x_q;
  assign bus.wr_y     = wr_y_q;
  assign bus.wr_m     = wr_m_q;
  assign bus.wr_m1    = wr_m1_q;
  assign bus.task_req = task_req_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.err      = err_q;

endmodule
